// File: rtl/gate_truth_checker_pkg.sv
// Shared definitions for the gate truth-table checker: FSM encoding, common gate truth tables,
// and the saturating mismatch counter helper. Optional feature macro: GATE_CHECK_FIRST_FAIL_EN.
package gate_check_pkg;

    typedef logic [1:0] gc_state_t;

    localparam gc_state_t ST_IDLE   = 2'd0;
    localparam gc_state_t ST_SETTLE = 2'd1;
    localparam gc_state_t ST_SAMPLE = 2'd2;
    localparam gc_state_t ST_DONE   = 2'd3;

    // Truth tables are indexed by {a,b}: bit 0 is a=0,b=0 and bit 3 is a=1,b=1.
    localparam logic [3:0] NAND_TRUTH = 4'b0111;
    localparam logic [3:0] AND_TRUTH  = 4'b1000;
    localparam logic [3:0] OR_TRUTH   = 4'b1110;
    localparam logic [3:0] NOR_TRUTH  = 4'b0001;
    localparam logic [3:0] XOR_TRUTH  = 4'b0110;

    localparam logic [2:0] ERR_MAX = 3'd4;

    function automatic logic [2:0] sat_inc(input logic [2:0] val);
        return (val >= ERR_MAX) ? val : val + 3'd1;
    endfunction

endpackage

// File: rtl/gate_truth_checker_if.sv
// Signal bundle between the truth-table checker (master) and the gate/test environment (slave).
// Optional feature macro: GATE_CHECK_FIRST_FAIL_EN adds the first-failure capture signals.
interface gate_truth_checker_if;

    logic       start;
    logic       a;
    logic       b;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
`ifdef GATE_CHECK_FIRST_FAIL_EN
    logic [2:0] first_fail;
    logic       first_fail_vld;

    modport master (
        input  start, y,
        output a, b, busy, done, pass, err_cnt, first_fail, first_fail_vld
    );
    modport slave (
        output start, y,
        input  a, b, busy, done, pass, err_cnt, first_fail, first_fail_vld
    );
`else
    modport master (
        input  start, y,
        output a, b, busy, done, pass, err_cnt
    );
    modport slave (
        output start, y,
        input  a, b, busy, done, pass, err_cnt
    );
`endif

endinterface

// File: rtl/gate_truth_checker_timer.sv
// Settle down-counter for the gate truth-table checker: load, count down to zero, zero flag.
// Optional feature macro GATE_CHECK_FIRST_FAIL_EN does not affect this module.
module gate_check_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_count,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives all four {a,b} vectors onto an external 2-input gate and checks y against GATE_TRUTH.
// Optional feature macro: GATE_CHECK_FIRST_FAIL_EN adds first_fail/first_fail_vld capture.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for start, a=b=0, last run result held
// ST_SETTLE | vector on {a,b}, waiting SETTLE_CYCLES for the gate output
// ST_SAMPLE | one cycle, y compared at the closing edge
// ST_DONE   | one-cycle done pulse, pass valid, {a,b} back to 00
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  GATE_TRUTH    = NAND_TRUTH
) (
    input  logic clk,
    input  logic rst_n,
    gate_truth_checker_if.master bus
);

    // The timer is loaded with SETTLE_CYCLES-1 so that SETTLE spans exactly SETTLE_CYCLES cycles.
    localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    gc_state_t  r_state;
    logic [1:0] r_vec;
    logic [2:0] r_err_cnt;
    logic       r_pass;
    logic       r_busy;
    logic       r_done;

    logic       w_start_ok;
    logic       w_mismatch;
    logic [2:0] w_err_next;
    logic       w_tmr_load;
    logic       w_tmr_count;
    logic       w_tmr_zero;

    assign w_start_ok  = (r_state == ST_IDLE) && bus.start;
    assign w_mismatch  = (bus.y != GATE_TRUTH[r_vec]);
    assign w_err_next  = w_mismatch ? sat_inc(r_err_cnt) : r_err_cnt;
    assign w_tmr_load  = w_start_ok || (r_state == ST_SAMPLE);
    assign w_tmr_count = (r_state == ST_SETTLE);

    gate_check_timer #(
        .W (4)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (LP_SETTLE_LOAD),
        .i_count    (w_tmr_count),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_vec     <= 2'b00;
            r_err_cnt <= 3'd0;
            r_pass    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state   <= ST_SETTLE;
                        r_vec     <= 2'b00;
                        r_err_cnt <= 3'd0;
                        r_pass    <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_tmr_zero) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_err_cnt <= w_err_next;
                    if (r_vec == 2'b11) begin
                        // pass must reflect the last vector's compare, hence w_err_next.
                        r_state <= ST_DONE;
                        r_vec   <= 2'b00;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 3'd0);
                    end else begin
                        r_vec   <= r_vec + 2'b01;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a       = r_vec[1];
    assign bus.b       = r_vec[0];
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.pass    = r_pass;
    assign bus.err_cnt = r_err_cnt;

`ifdef GATE_CHECK_FIRST_FAIL_EN
    logic [2:0] r_first_fail;
    logic       r_first_fail_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first_fail     <= 3'b000;
            r_first_fail_vld <= 1'b0;
        end else if (w_start_ok) begin
            r_first_fail     <= 3'b000;
            r_first_fail_vld <= 1'b0;
        end else if ((r_state == ST_SAMPLE) && w_mismatch && !r_first_fail_vld) begin
            r_first_fail     <= {r_vec, bus.y};
            r_first_fail_vld <= 1'b1;
        end
    end

    assign bus.first_fail     = r_first_fail;
    assign bus.first_fail_vld = r_first_fail_vld;
`endif

endmodule

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter SHALL be: SETTLE_CYCLES, 1, cycles each input vector is held before y is sampled (legal range 1..15).
REQ-003 Parameter SHALL be: GATE_TRUTH, 4'b0111, expected y indexed by {a,b} (4'b0111 is NAND).
REQ-004 Port SHALL be: clk  input  1  system clock, rising edge.
REQ-005 Port SHALL be: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port SHALL be: start  input  1  begin one full truth-table run; sampled only in IDLE.
REQ-007 Port SHALL be: a  output  1  gate-under-test input a.
REQ-008 Port SHALL be: b  output  1  gate-under-test input b.
REQ-009 Port SHALL be: y  input  1  gate-under-test output.
REQ-010 Port SHALL be: busy  output  1  high from the cycle after start is accepted until done.
REQ-011 Port SHALL be: done  output  1  one-cycle pulse at end of run.
REQ-012 Port SHALL be: pass  output  1  run result, valid from done, held until next accepted start.
REQ-013 Port SHALL be: err_cnt  output  3  mismatch count for the run (0..4).

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE; reset state IDLE.
REQ-015 IDLE with start=1 at edge k SHALL: load vector 00 onto {a,b}, clear err_cnt and pass, enter SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles (down-counter), then enter SAMPLE.
REQ-017 SAMPLE SHALL last one cycle; at its closing edge y is compared to GATE_TRUTH[{a,b}]; on mismatch err_cnt increments (saturating at 4).
REQ-018 After SAMPLE: if vector is 11, enter DONE; otherwise increment vector (00,01,10,11 order) and return to SETTLE.
REQ-019 Each vector SHALL be held SETTLE_CYCLES+1 cycles; done SHALL be high in the cycle after edge k+4*(SETTLE_CYCLES+1).
REQ-020 DONE SHALL last one cycle: done=1, pass=(final err_cnt==0), {a,b} return to 00, then go to IDLE.
REQ-021 start SHALL be ignored in SETTLE, SAMPLE and DONE; no queuing.
REQ-022 start held continuously high SHALL begin a new run in the first IDLE cycle after DONE.
REQ-023 In IDLE, a=b=0 and busy=0; pass and err_cnt hold their last run values.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, counters 0.
REQ-025 Reset mid-run SHALL abort the run with no done pulse; the first start after release SHALL run all four vectors from 00.

Configuration
REQ-026 Macro GATE_CHECK_FIRST_FAIL_EN defined: port first_fail  output  3  {a,b,y} of the first mismatching vector in the run, plus first_fail_vld output 1; both clear on accepted start and on reset.
REQ-027 Macro undefined: first_fail and first_fail_vld ports and their registers SHALL not exist; all other behaviour is identical.

Structure
REQ-028 Shared package gate_check_pkg SHALL hold the FSM state encoding and truth constants NAND_TRUTH=4'b0111, AND_TRUTH=4'b1000, OR_TRUTH=4'b1110, NOR_TRUTH=4'b0001, XOR_TRUTH=4'b0110.
REQ-029 The settle down-counter SHALL be the one sub-module, gate_check_timer (load, count, zero flag); the gate under test SHALL remain external.

Verification
REQ-030 Correct NAND on y, SETTLE_CYCLES=1, start pulse -> {a,b}=00,01,10,11 for 2 cycles each; done at edge k+8; pass=1, err_cnt=0.
REQ-031 y tied 0, GATE_TRUTH=NAND -> err_cnt=3, pass=0; with macro, first_fail=3'b000, first_fail_vld=1.
REQ-032 y driven by an AND gate, GATE_TRUTH=NAND -> err_cnt=4, pass=0; with macro, first_fail=3'b000.
REQ-033 Extra start pulses at edges k+3 and k+8 -> exactly one done (edge k+8), busy continuous, no restart.
REQ-034 rst_n low at edge k+5 -> all outputs 0 immediately, no done; a start after release -> full passing run.
REQ-035 GATE_TRUTH=OR_TRUTH, SETTLE_CYCLES=3, OR gate on y -> done at edge k+16, pass=1, err_cnt=0.
